// File: rtl/lcd_ctrl.sv
// HD44780-style 16x2 character LCD controller: power-up wait, init, endless refresh.
// Define LCD_CTRL_CURSOR_EN to enable the blinking cursor in the display-control command.
module lcd_ctrl #(
    parameter int TICK_DIV       = 50000,
    parameter int POWERUP_TICKS  = 20,
    parameter int CLR_WAIT_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_clk,
    output logic [7:0] lcd_data
);

    localparam int TW   = $clog2(TICK_DIV);
    localparam int WMAX = (POWERUP_TICKS > CLR_WAIT_TICKS) ?
                          POWERUP_TICKS : CLR_WAIT_TICKS;
    localparam int WW   = $clog2(WMAX + 1);

`ifdef LCD_CTRL_CURSOR_EN
    localparam logic [7:0] DISPCTL = 8'h0F;
`else
    localparam logic [7:0] DISPCTL = 8'h0C;
`endif

    typedef enum logic [1:0] {PWR_WAIT, INIT, CLR_WAIT, REFRESH} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, HOLD} step_t;

    state_t        state, state_n;
    step_t         step, step_n;
    logic [TW-1:0] timer;
    logic [5:0]    idx, idx_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic          phase_end;
    logic          load;
    logic          done_n;
    logic          rs_n;
    logic [7:0]    byte_n;
    logic [7:0]    mem [32];

    assign phase_end = (timer == TW'(TICK_DIV - 1));
    assign wr_ready  = ~rst;
    assign lcd_rw    = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PWR_WAIT;
            step  <= SETUP;
            timer <= '0;
            idx   <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            step  <= step_n;
            timer <= phase_end ? '0 : timer + TW'(1);
            idx   <= idx_n;
            wcnt  <= wcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        step_n  = step;
        idx_n   = idx;
        wcnt_n  = wcnt;
        load    = 1'b0;
        done_n  = init_done;
        if (phase_end) begin
            case (state)
                PWR_WAIT: begin
                    if (wcnt == WW'(POWERUP_TICKS - 1)) begin
                        state_n = INIT;
                        wcnt_n  = '0;
                        idx_n   = '0;
                        step_n  = SETUP;
                        load    = 1'b1;
                    end else begin
                        wcnt_n = wcnt + WW'(1);
                    end
                end
                CLR_WAIT: begin
                    if (wcnt == WW'(CLR_WAIT_TICKS - 1)) begin
                        state_n = REFRESH;
                        wcnt_n  = '0;
                        idx_n   = '0;
                        step_n  = SETUP;
                        load    = 1'b1;
                        done_n  = 1'b1;
                    end else begin
                        wcnt_n = wcnt + WW'(1);
                    end
                end
                default: begin
                    case (step)
                        SETUP: step_n = PULSE;
                        PULSE: step_n = HOLD;
                        default: begin
                            step_n = SETUP;
                            if (state == INIT && idx == 6'd5) begin
                                state_n = CLR_WAIT;
                                idx_n   = '0;
                            end else if (state == REFRESH && idx == 6'd33) begin
                                idx_n = '0;
                                load  = 1'b1;
                            end else begin
                                idx_n = idx + 6'd1;
                                load  = 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    // Byte for the transfer about to start; buffer is read on the SETUP-entry edge.
    always_comb begin
        rs_n   = 1'b0;
        byte_n = 8'h00;
        unique case (1'b1)
            state_n == INIT: begin
                case (idx_n)
                    6'd0, 6'd1, 6'd2: byte_n = 8'h38;
                    6'd3:             byte_n = DISPCTL;
                    6'd4:             byte_n = 8'h06;
                    default:          byte_n = 8'h01;
                endcase
            end
            state_n != INIT && idx_n == 6'd0:  byte_n = 8'h80;
            state_n != INIT && idx_n == 6'd17: byte_n = 8'hC0;
            state_n != INIT && idx_n >= 6'd1 && idx_n <= 6'd16: begin
                rs_n   = 1'b1;
                byte_n = mem[5'(idx_n - 6'd1)];
            end
            state_n != INIT && idx_n >= 6'd18: begin
                rs_n   = 1'b1;
                byte_n = mem[5'(idx_n - 6'd2)];
            end
            default: byte_n = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_done <= 1'b0;
            lcd_clk   <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
        end else begin
            init_done <= done_n;
            lcd_clk   <= (state_n == INIT || state_n == REFRESH) &&
                         (step_n == PULSE);
            if (load) begin
                lcd_rs   <= rs_n;
                lcd_data <= byte_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
        end else if (wr_valid && wr_ready) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected LCD transfers queued, popped on each enable rise.
// Define LCD_CTRL_CURSOR_EN to expect the cursor-on display-control command.
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_clk;
    logic [7:0] lcd_data;

`ifdef LCD_CTRL_CURSOR_EN
    localparam logic [7:0] EXP_DISP = 8'h0F;
`else
    localparam logic [7:0] EXP_DISP = 8'h0C;
`endif

    lcd_ctrl #(
        .TICK_DIV(4),
        .POWERUP_TICKS(2),
        .CLR_WAIT_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .init_done(init_done),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_clk(lcd_clk),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_xfer = 0;
    int         done_cyc = -1;
    bit         done_seen = 0;
    bit         abort = 0;
    int         rise_cyc [80];
    logic [8:0] exp_q [$];
    logic [7:0] mdl [32];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, EXP_DISP});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h01});
    endtask

    task automatic push_pass();
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, mdl[i]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, mdl[i]});
    endtask

    task automatic wait_xfer(input int n, input int budget);
        int k = 0;
        while (n_xfer < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("wait_xfer", 32'(n_xfer >= n), 32'd1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc = rst ? 0 : cyc + 1;
    end

    // Transfer monitor: pops the scoreboard on every rising enable.
    initial begin
        logic [8:0] hist [4];
        logic [8:0] cur, hi_ref;
        logic       clk_q;
        int         hi_cnt;
        clk_q  = 1'b0;
        hi_cnt = 0;
        hi_ref = '0;
        for (int i = 0; i < 4; i++) hist[i] = '0;
        forever begin
            @(negedge clk);
            cur = {lcd_rs, lcd_data};
            if (cyc == 0) begin
                n_xfer    = 0;
                done_seen = 0;
            end
            if (lcd_clk && !clk_q) begin
                chk("setup_stable", 32'(hist[3]), 32'(cur));
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL xfer unexpected got %0h exp none", cur);
                end
                if (exp_q.size() != 0) chk("xfer", 32'(cur), 32'(exp_q.pop_front()));
                if (n_xfer < 80) rise_cyc[n_xfer] = cyc;
                n_xfer++;
                hi_cnt = 1;
                hi_ref = cur;
                abort  = 0;
            end else if (lcd_clk) begin
                hi_cnt++;
                chk("pulse_stable", 32'(cur), 32'(hi_ref));
            end else if (clk_q && !abort) begin
                chk("pulse_width", 32'(hi_cnt), 32'd4);
            end
            if (done_seen && cyc != 0) chk("done_sticky", 32'(init_done), 32'd1);
            if (init_done && !done_seen) begin
                done_seen = 1;
                done_cyc  = cyc;
            end
            clk_q = lcd_clk;
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = cur;
        end
    end

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_clk", 32'(lcd_clk), 32'd0);
        chk("rst_rs", 32'(lcd_rs), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'h00);
        chk("rst_rw", 32'(lcd_rw), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);

        push_init();
        mdl[0]  = 8'h48;
        mdl[31] = 8'h21;
        push_pass();
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 8'h48;
        #1 chk("ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        wr_addr = 5'd31;
        wr_data = 8'h21;
        @(negedge clk);
        wr_valid = 1'b0;

        wait_xfer(40, 800);
        chk("first_rise", 32'(rise_cyc[0]), 32'd12);
        chk("done_cyc", 32'(done_cyc), 32'd88);
        chk("pass1_rise", 32'(rise_cyc[6]), 32'd92);

        mdl[16] = 8'h5A;
        push_pass();
        exp_q.push_back({1'b0, 8'h80});
        wr_valid = 1'b1;
        wr_addr  = 5'd16;
        wr_data  = 8'h5A;
        @(negedge clk);
        wr_valid = 1'b0;

        wait_xfer(75, 800);
        chk("pass1_span", 32'(rise_cyc[40] - rise_cyc[6]), 32'd408);
        chk("pass2_span", 32'(rise_cyc[74] - rise_cyc[40]), 32'd408);

        chk("in_pulse", 32'(lcd_clk), 32'd1);
        abort = 1;
        rst   = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_clk", 32'(lcd_clk), 32'd0);
        chk("mid_rst_done", 32'(init_done), 32'd0);
        chk("mid_rst_data", 32'(lcd_data), 32'h00);
        chk("mid_rst_ready", 32'(wr_ready), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
        push_init();
        push_pass();

        wait_xfer(40, 800);
        chk("re_first_rise", 32'(rise_cyc[0]), 32'd12);
        chk("re_done_cyc", 32'(done_cyc), 32'd88);
        chk("re_pass_rise", 32'(rise_cyc[6]), 32'd92);
        chk("re_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
